// File: rtl/cosim_manifest_streamer_if.sv
// Command/response handshake bundle for the cosim manifest streamer.
// Master issues byte-addressed reads and consumes beats; slave serves them.
interface cosim_manifest_streamer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_BYTES = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic                    cmd_stream;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [8*BEAT_BYTES-1:0] resp_data;
    logic                    resp_last;
    logic                    resp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_stream, resp_ready,
        input  cmd_ready, resp_valid, resp_data, resp_last, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_stream, resp_ready,
        output cmd_ready, resp_valid, resp_data, resp_last, resp_err
    );
endinterface

// File: rtl/cosim_manifest_streamer.sv
// Serves a snapshotted compressed manifest plus a 4-beat header
// over a command/response stream, tracking manifest generations.
module cosim_manifest_streamer #(
    parameter int          COMPRESSED_MANIFEST_SIZE = 1,
    parameter int unsigned ESI_VERSION              = 1,
    parameter int          BEAT_BYTES               = 8,
    parameter int          ADDR_WIDTH               = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [COMPRESSED_MANIFEST_SIZE-1:0][7:0] compressed_manifest,
    cosim_manifest_streamer_if.slave bus,
    output logic [31:0] generation,
    output logic        busy
);
    localparam int SIZE = COMPRESSED_MANIFEST_SIZE;
    localparam int BB   = BEAT_BYTES;
    localparam int W    = 8 * BB;
    localparam int SH   = $clog2(BB);
    localparam int N    = (SIZE + BB - 1) / BB;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(3 + N);

    typedef enum logic [1:0] {IDLE, SINGLE, STREAM} state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     cur_b;
    logic [ADDR_WIDTH-1:0]     sel_b;
    logic [SIZE-1:0][7:0]      snap;
    logic [SIZE-1:0][7:0]      sel_snap;
    logic [N*BB-1:0][7:0]      padded;
    logic [31:0]               sel_gen;
    logic [63:0]               hdr;
    logic [W-1:0]              sel_data;
    logic                      sel_err;
    logic                      change;
    logic                      hs;

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = ~bus.cmd_ready;
    assign change        = (compressed_manifest != snap);
    assign hs            = bus.resp_valid && bus.resp_ready;

    // In IDLE the beat is built from the post-update snapshot so a
    // change and an accept in the same cycle serve the new manifest.
    always_comb begin
        sel_b    = (state == IDLE) ? (bus.cmd_addr >> SH)
                                   : (cur_b + ADDR_WIDTH'(1));
        sel_snap = (state == IDLE && change) ? compressed_manifest : snap;
        sel_gen  = (state == IDLE && change) ? generation + 32'd1
                                             : generation;
        padded = '0;
        for (int k = 0; k < SIZE; k++) begin
            padded[k] = sel_snap[k];
        end
        hdr = '0;
        if (sel_b == ADDR_WIDTH'(0)) begin
            hdr = 64'(ESI_VERSION);
        end else if (sel_b == ADDR_WIDTH'(1)) begin
            hdr = 64'(COMPRESSED_MANIFEST_SIZE);
        end else if (sel_b == ADDR_WIDTH'(2)) begin
            hdr = 64'(sel_gen);
        end
        sel_data = hdr[W-1:0];
        for (int i = 0; i < N; i++) begin
            if (sel_b == ADDR_WIDTH'(4 + i)) begin
                sel_data = padded[i*BB +: BB];
            end
        end
        sel_err = (sel_b > LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_b          <= '0;
            snap           <= '0;
            generation     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_last  <= 1'b0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (change) begin
                        snap       <= compressed_manifest;
                        generation <= generation + 32'd1;
                    end
                    if (bus.cmd_valid) begin
                        cur_b          <= sel_b;
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= sel_data;
                        bus.resp_err   <= sel_err;
                        bus.resp_last  <= !bus.cmd_stream || sel_err
                                          || (sel_b == LAST);
                        state <= (bus.cmd_stream && !sel_err) ? STREAM
                                                              : SINGLE;
                    end
                end
                SINGLE: begin
                    if (hs) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (cur_b == LAST) begin
                            bus.resp_valid <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            cur_b         <= sel_b;
                            bus.resp_data <= sel_data;
                            bus.resp_err  <= sel_err;
                            bus.resp_last <= (sel_b == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cosim_manifest_streamer.md
COSIM_MANIFEST_STREAMER -- requirements
Module: cosim_manifest_streamer

Interface
REQ-001 SHALL have parameter COMPRESSED_MANIFEST_SIZE, default 1: manifest length in bytes, at least 1.
REQ-002 SHALL have parameter ESI_VERSION, default 1: int unsigned, returned in header beat 0.
REQ-003 SHALL have parameter BEAT_BYTES, default 8: bytes per response beat; legal values 1, 2, 4, 8.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32: command byte-address width.
REQ-005 SHALL have ports, with one clock and a synchronous active-low reset:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- compressed_manifest  in  [COMPRESSED_MANIFEST_SIZE-1:0][7:0]  zlib manifest, byte 0 first
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  byte address; low log2(BEAT_BYTES) bits ignored
- cmd_stream  in  1  0 = single beat, 1 = stream from cmd_addr to last data beat
- resp_valid  out  1  response beat valid
- resp_ready  in  1  response beat consumed
- resp_data  out  8*BEAT_BYTES  beat payload
- resp_last  out  1  final beat of the command
- resp_err  out  1  beat index out of range
- generation  out  32  manifest change count
- busy  out  1  command in flight

Function
REQ-006 Beat index b SHALL equal cmd_addr divided by BEAT_BYTES; N = ceil(COMPRESSED_MANIFEST_SIZE / BEAT_BYTES); the last valid beat is L = 3 + N.
REQ-007 Beat contents SHALL be: b=0 ESI_VERSION; b=1 COMPRESSED_MANIFEST_SIZE; b=2 generation; b=3 zero. Each value is zero-extended or truncated to 8*BEAT_BYTES bits.
REQ-008 Beats b=4..L SHALL carry snapshot byte k in lane k mod BEAT_BYTES of beat 4 + k/BEAT_BYTES, little-endian. Lanes past the last byte read zero.
REQ-009 A beat with b>L SHALL return resp_data=0 and resp_err=1; every other beat returns resp_err=0.
REQ-010 The FSM SHALL have three states: IDLE, SINGLE and STREAM. cmd_ready=1 only in IDLE. busy is the inverse of cmd_ready.
REQ-011 Transitions SHALL be:
- IDLE to SINGLE on accept with cmd_stream=0, or with b>L regardless of cmd_stream.
- IDLE to STREAM on accept with cmd_stream=1 and b<=L.
- SINGLE to IDLE on a resp handshake.
- STREAM advances b by 1 on each handshake and goes to IDLE on the handshake of beat L.
REQ-012 resp_valid SHALL rise the cycle after cmd accept (latency 1). While resp_ready=0, resp_valid and all resp_* outputs SHALL hold stable.
REQ-013 In STREAM, back-to-back handshakes SHALL give one beat per cycle with no bubbles.
REQ-014 resp_last SHALL be 1 on SINGLE beats and on beat L of a stream; it is 0 on all other beats.
REQ-015 A new cmd SHALL be accepted no earlier than the cycle after the final resp handshake; there is no overlap.
REQ-016 The snapshot register SHALL hold the served manifest. In IDLE, if compressed_manifest differs from the snapshot, the snapshot loads the input and generation increments by 1.
REQ-017 While busy, the snapshot and generation SHALL NOT update. A change seen during a command is applied in the first IDLE cycle after it.
REQ-018 Generation SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 If a change and a cmd accept occur in the same IDLE cycle, the response SHALL use the updated snapshot and generation.

Reset
REQ-020 With rst_n=0 at a clk edge, the block SHALL set: state IDLE, resp_valid=0, resp_last=0, resp_err=0, resp_data=0, generation=0, snapshot=0. cmd_ready=1 from the first cycle after reset.
REQ-021 Reset mid-command SHALL abort the command with no further beats. The first IDLE cycle after reset with a nonzero manifest sets generation=1.

Verification
REQ-022 BEAT_BYTES=8, SIZE=10, ESI_VERSION=1, single reads at addr 0, 8, 16 -> results:
- addr 0 returns 1.
- addr 8 returns 10.
- addr 16 returns the generation.
- Each response arrives one cycle after accept with resp_last=1.
REQ-023 Same configuration, stream from addr 32, resp_ready always 1 -> two consecutive beats:
- Bytes 0..7, then bytes 8..9 with upper lanes zero.
- resp_last=1 on the second beat only.
REQ-024 Single read at addr 48 (b=6 > L=5) -> resp_data=0, resp_err=1, resp_last=1. A stream request at that address gives the same single error beat.
REQ-025 Stream with resp_ready toggling 1/0 every cycle -> outputs stable while stalled, no beats lost or duplicated.
REQ-026 Manifest changed mid-stream -> results:
- Remaining beats carry the old bytes.
- generation increments exactly once, in the first IDLE cycle.
- A following read returns the new bytes.
REQ-027 rst_n asserted during a stream -> next cycle resp_valid=0, cmd_ready=1, generation=0. A new command then completes normally.
